// File: rtl/fetch_pc_ctrl_if.sv
// Fetch-PC control bundle: D-stage request, check, and exception inputs; fetch PC and status outputs.
// Latency: wiring only.
// Backpressure: ra_stall is returned to the D-stage producer.
interface fetch_pc_ctrl_if #(
    parameter int RAS_DEPTH = 4,
    parameter int CNT_W     = 16
);
    localparam int RC_W = $clog2(RAS_DEPTH) + 1;

    // D-stage and redirect inputs
    logic              stall;
    logic [2:0]        npc_op;
    logic [31:0]       d_pc;
    logic [25:0]       index;
    logic [15:0]       offset;
    logic              cmp_out;
    logic [31:0]       ra;
    logic              ra_ready;
    logic              chk_valid;
    logic [31:0]       chk_ra;
    logic              exc_req;
    logic              eret;
    logic [31:0]       epc;

    // Fetch-side outputs
    logic [31:0]       pc;
    logic              flush;
    logic              ra_stall;
    logic              pred_pending;
    logic [RC_W-1:0]   ras_count;
    logic [CNT_W-1:0]  mispred_cnt;

    // The D stage or a testbench drives requests and observes the fetch state
    modport master (
        output stall, npc_op, d_pc, index, offset, cmp_out, ra, ra_ready,
               chk_valid, chk_ra, exc_req, eret, epc,
        input  pc, flush, ra_stall, pred_pending, ras_count, mispred_cnt
    );

    // The fetch PC controller consumes requests and produces the fetch state
    modport slave (
        input  stall, npc_op, d_pc, index, offset, cmp_out, ra, ra_ready,
               chk_valid, chk_ra, exc_req, eret, epc,
        output pc, flush, ra_stall, pred_pending, ras_count, mispred_cnt
    );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// F-stage PC register with next-PC select, return-address stack prediction, mispredict and exception redirect.
// Latency: a decision made in cycle N appears on pc in cycle N+1; flush is a registered 1-cycle pulse.
// Backpressure: stall holds the PC; ra_stall (comb) asks upstream to hold when JR_RA can be neither resolved nor predicted.
module fetch_pc_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] EXC_VEC   = 32'h0000_4180,
    parameter int          RAS_DEPTH = 4,
    parameter int          CNT_W     = 16
) (
    input  logic          clk,
    input  logic          reset,
    fetch_pc_ctrl_if.slave bus
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int RC_W  = PTR_W + 1;

    localparam logic [2:0] OP_BR    = 3'b001;
    localparam logic [2:0] OP_JR    = 3'b010;
    localparam logic [2:0] OP_J     = 3'b011;
    localparam logic [2:0] OP_JAL   = 3'b100;
    localparam logic [2:0] OP_JR_RA = 3'b101;

    logic [31:0]      pc_q, pc_d;
    logic             pend_q, pend_d;
    logic [31:0]      tgt_q, tgt_d;
    logic             flush_q, flush_d;
    logic [CNT_W-1:0] mis_q, mis_d;
    logic [31:0]      ras_q [RAS_DEPTH];
    logic [PTR_W-1:0] sp_q;
    logic [RC_W-1:0]  count_q;

    logic             push, pop;
    logic [31:0]      push_val;
    logic [31:0]      ras_top;
    logic [31:0]      pc_plus4;
    logic [31:0]      br_tgt;
    logic [31:0]      j_tgt;
    logic             ras_empty;
    logic             ras_full;
    logic             pend_live;
    logic             mispredict;
    logic             ra_stall;
    logic             hold;

    // sp_q points at the next free slot; the newest entry sits just below it
    assign ras_top   = ras_q[sp_q - PTR_W'(1)];
    assign ras_empty = (count_q == '0);
    assign ras_full  = (count_q == RC_W'(RAS_DEPTH));

    assign pc_plus4 = pc_q + 32'd4;
    assign br_tgt   = bus.d_pc + 32'd4 + {{14{bus.offset[15]}}, bus.offset, 2'b00};
    assign j_tgt    = {bus.d_pc[31:28], bus.index, 2'b00};
    assign push_val = bus.d_pc + 32'd8;

    // A check presented this cycle retires the outstanding prediction, so a new one may start
    assign pend_live  = pend_q & ~bus.chk_valid;
    assign mispredict = pend_q & bus.chk_valid & (bus.chk_ra != tgt_q);
    assign ra_stall   = (bus.npc_op == OP_JR_RA) & ~bus.ra_ready & (ras_empty | pend_live);
    assign hold       = bus.stall | ra_stall;

    // Next-PC select in priority order: exception, eret, mispredict fix, hold, D op, sequential
    always_comb begin
        pc_d    = pc_q;
        pend_d  = pend_q;
        tgt_d   = tgt_q;
        flush_d = 1'b0;
        mis_d   = mis_q;
        push    = 1'b0;
        pop     = 1'b0;
        if (bus.exc_req) begin
            pc_d    = EXC_VEC;
            flush_d = 1'b1;
            pend_d  = 1'b0;
        end else if (bus.eret) begin
            pc_d    = bus.epc;
            flush_d = 1'b1;
            pend_d  = 1'b0;
        end else if (mispredict) begin
            pc_d    = bus.chk_ra;
            flush_d = 1'b1;
            pend_d  = 1'b0;
            mis_d   = mis_q + CNT_W'(1);
        end else begin
            if (pend_q && bus.chk_valid) begin
                pend_d = 1'b0;
            end
            if (!hold) begin
                case (bus.npc_op)
                    OP_BR:  pc_d = bus.cmp_out ? br_tgt : pc_plus4;
                    OP_JR:  pc_d = bus.ra;
                    OP_J:   pc_d = j_tgt;
                    OP_JAL: begin
                        pc_d = j_tgt;
                        push = 1'b1;
                    end
                    OP_JR_RA: begin
                        if (bus.ra_ready) begin
                            pc_d = bus.ra;
                            pop  = ~ras_empty;
                        end else begin
                            // Not held, so the stack is non-empty and no prediction is live
                            pc_d   = ras_top;
                            pop    = 1'b1;
                            tgt_d  = ras_top;
                            pend_d = 1'b1;
                        end
                    end
                    default: pc_d = pc_plus4;
                endcase
            end
        end
    end

    // PC, prediction, flush and mispredict-count registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            pend_q  <= 1'b0;
            tgt_q   <= '0;
            flush_q <= 1'b0;
            mis_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            tgt_q   <= tgt_d;
            flush_q <= flush_d;
            mis_q   <= mis_d;
        end
    end

    // Stack pointer and occupancy; a push into a full stack overwrites the oldest slot
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp_q    <= '0;
            count_q <= '0;
        end else if (push) begin
            sp_q    <= sp_q + PTR_W'(1);
            count_q <= ras_full ? count_q : count_q + RC_W'(1);
        end else if (pop) begin
            sp_q    <= sp_q - PTR_W'(1);
            count_q <= count_q - RC_W'(1);
        end
    end

    // Stack storage; contents are only meaningful below the occupancy count, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            ras_q[sp_q] <= push_val;
        end
    end

    assign bus.pc           = pc_q;
    assign bus.flush        = flush_q;
    assign bus.ra_stall     = ra_stall;
    assign bus.pred_pending = pend_q;
    assign bus.ras_count    = count_q;
    assign bus.mispred_cnt  = mis_q;
endmodule
